// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and small helpers
//
// Data width is common to the receiver, transmitter and the receive FIFO.
// Default FIFO sizing lives here so every instantiation site agrees.

package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int RX_FIFO_DEPTH     = 16;
    localparam int RX_FIFO_AF_THRESH = 12;

    // Saturating 8-bit increment: holds at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x W storage array, sync write, async read
//
// Ports:
//   clk_i      : clock for the write port
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_addr_i  : read address (combinational read)
//   rd_data_o  : data at rd_addr_i
//
// Kept apart from the pointer logic so it can be swapped for a RAM macro.

module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);

    // No reset: contents are meaningless until written.
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte FIFO, first-word-fall-through
//
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   rx_data_i       : received byte, qualified by rx_done_i
//   rx_done_i       : one-cycle write strobe from the receiver
//   rd_ready_i      : consumer takes rd_data_o this cycle
//   ovr_clr_i       : clears overrun_o and ovr_count_o
//   rd_data_o       : head byte (0 when empty)
//   rd_valid_o      : head byte present
//   level_o         : stored byte count, 0..DEPTH
//   full_o          : level == DEPTH
//   almost_full_o   : level >= AF_THRESH
//   overrun_o       : sticky, a byte was dropped
//   ovr_count_o     : dropped byte count, saturating at 255

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = RX_FIFO_DEPTH,
    parameter int AF_THRESH = RX_FIFO_AF_THRESH
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [UART_DATA_BITS-1:0] rx_data_i,
    input  logic                      rx_done_i,
    input  logic                      rd_ready_i,
    input  logic                      ovr_clr_i,
    output logic [UART_DATA_BITS-1:0] rd_data_o,
    output logic                      rd_valid_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      full_o,
    output logic                      almost_full_o,
    output logic                      overrun_o,
    output logic [7:0]                ovr_count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_LEVEL = PW'(AF_THRESH);

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    ovr_count_q, ovr_count_d;

    logic                      empty;
    logic                      full;
    logic                      rd_fire;
    logic                      wr_en;
    logic                      drop;
    logic [UART_DATA_BITS-1:0] mem_rd_data;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign rd_fire = !empty && rd_ready_i;
    // A read in the same cycle frees the slot, so a full buffer still accepts.
    assign wr_en   = rx_done_i && (!full || rd_fire);
    assign drop    = rx_done_i && full && !rd_fire;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (UART_DATA_BITS)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (rx_data_i),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (mem_rd_data)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overrun_d   = overrun_q;
        ovr_count_d = ovr_count_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({wr_en, rd_fire})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as a clear starts a fresh count of one.
        if (drop) begin
            overrun_d   = 1'b1;
            ovr_count_d = ovr_clr_i ? 8'd1 : sat_inc8(ovr_count_q);
        end else if (ovr_clr_i) begin
            overrun_d   = 1'b0;
            ovr_count_d = 8'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overrun_q   <= 1'b0;
            ovr_count_q <= 8'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overrun_q   <= overrun_d;
            ovr_count_q <= ovr_count_d;
        end
    end

    assign rd_valid_o    = !empty;
    assign rd_data_o     = empty ? '0 : mem_rd_data;
    assign level_o       = level_q;
    assign full_o        = full;
    assign almost_full_o = (level_q >= AF_LEVEL);
    assign overrun_o     = overrun_q;
    assign ovr_count_o   = ovr_count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard testbench for uart_rx_fifo

module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       rd_ready = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] level;
    logic       full;
    logic       almost_full;
    logic       overrun;
    logic [7:0] ovr_count;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH     (DEPTH),
        .AF_THRESH (12)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rx_data_i     (rx_data),
        .rx_done_i     (rx_done),
        .rd_ready_i    (rd_ready),
        .ovr_clr_i     (ovr_clr),
        .rd_data_o     (rd_data),
        .rd_valid_o    (rd_valid),
        .level_o       (level),
        .full_o        (full),
        .almost_full_o (almost_full),
        .overrun_o     (overrun),
        .ovr_count_o   (ovr_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake on the read side must match the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got 0x%0h expected no data", rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    fails++;
                    $display("FAIL sb_data: got 0x%0h expected 0x%0h", rd_data, e);
                end
            end
        end
    end

    // Drive one cycle of inputs just after a rising edge. exp_q.size() equals the
    // stored count at this point, which decides whether the write is accepted.
    task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
        int  lvl;
        logic fire;
        @(posedge clk);
        #1;
        rx_done  = wr;
        rx_data  = d;
        rd_ready = rd;
        ovr_clr  = clr;
        lvl  = exp_q.size();
        fire = rd && (lvl > 0);
        if (wr && (lvl < DEPTH || fire)) exp_q.push_back(d);
    endtask

    // Commit the last driven cycle and go idle; state is then checkable.
    task automatic sync();
        @(posedge clk);
        #1;
        rx_done  = 1'b0;
        rd_ready = 1'b0;
        ovr_clr  = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_ovr_count", ovr_count, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        sync();

        // Three bytes in, then three out
        step(1, 8'h41, 0, 0);
        step(1, 8'h42, 0, 0);
        step(1, 8'h43, 0, 0);
        sync();
        chk("t1_level", level, 3);
        chk("t1_head", rd_data, 8'h41);
        chk("t1_valid", rd_valid, 1);
        repeat (3) step(0, 8'h00, 1, 0);
        sync();
        chk("t1_empty_valid", rd_valid, 0);
        chk("t1_empty_level", level, 0);
        chk("t1_empty_data", rd_data, 0);

        // Fill to full, checking threshold flags per write, then overflow
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i), 0, 0);
            sync();
            chk($sformatf("t2_af_%0d", i + 1), almost_full, (i + 1 >= 12) ? 1 : 0);
            chk($sformatf("t2_full_%0d", i + 1), full, (i == 15) ? 1 : 0);
        end
        step(1, 8'hAA, 0, 0);
        sync();
        chk("t2_overrun", overrun, 1);
        chk("t2_ovr_count", ovr_count, 1);
        chk("t2_level", level, 16);
        chk("t2_head", rd_data, 8'h00);
        step(0, 8'h00, 0, 1);
        sync();
        chk("t2_clr_overrun", overrun, 0);
        chk("t2_clr_count", ovr_count, 0);

        // Full plus simultaneous read and write
        step(1, 8'h55, 1, 0);
        sync();
        chk("t3_level", level, 16);
        chk("t3_overrun", overrun, 0);
        chk("t3_full", full, 1);
        repeat (15) step(0, 8'h00, 1, 0);
        sync();
        chk("t3_last_head", rd_data, 8'h55);
        chk("t3_last_level", level, 1);
        step(0, 8'h00, 1, 0);
        sync();
        chk("t3_drained", level, 0);

        // Saturating drop counter, then clear racing a drop
        for (int i = 0; i < 16; i++) step(1, 8'(8'hC0 + i), 0, 0);
        repeat (300) step(1, 8'hEE, 0, 0);
        sync();
        chk("t4_sat_count", ovr_count, 255);
        chk("t4_overrun", overrun, 1);
        chk("t4_level", level, 16);
        step(1, 8'hEF, 0, 1);
        sync();
        chk("t4_race_overrun", overrun, 1);
        chk("t4_race_count", ovr_count, 1);
        step(0, 8'h00, 0, 1);
        sync();
        chk("t4_final_clr", ovr_count, 0);
        repeat (16) step(0, 8'h00, 1, 0);
        sync();
        chk("t4_drained", level, 0);

        // Pointer wrap with random spacing and read pressure
        for (int i = 0; i < 40; i++) begin
            step(1, 8'(i * 7 + 3), 1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 2)) step(0, 8'h00, 1'($urandom_range(0, 1)), 0);
            sync();
            chk($sformatf("t5_level_%0d", i), level, exp_q.size());
        end
        for (int n = 0; n < 64 && exp_q.size() > 0; n++) step(0, 8'h00, 1, 0);
        sync();
        chk("t5_drained", level, 0);

        // Asynchronous reset with bytes buffered
        for (int i = 0; i < 5; i++) step(1, 8'(8'h90 + i), 0, 0);
        sync();
        chk("t6_level_pre", level, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", rd_valid, 0);
        chk("t6_rst_level", level, 0);
        chk("t6_rst_full", full, 0);
        chk("t6_rst_data", rd_data, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sync();
        chk("t6_post_valid", rd_valid, 0);
        step(1, 8'h77, 0, 0);
        sync();
        chk("t6_post_level", level, 1);
        chk("t6_post_head", rd_data, 8'h77);
        step(0, 8'h00, 1, 0);
        sync();
        chk("t6_post_empty", rd_valid, 0);

        chk("sb_all_consumed", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each completed byte (`rx_data` qualified by the one-cycle `rx_done` pulse) into a circular buffer and presents the bytes to the host side through a first-word-fall-through valid/ready interface. It tracks fill level and a programmable almost-full threshold. Bytes arriving while the buffer is full are dropped, and a sticky overrun is flagged and counted.

## Interface
- `DEPTH`, 16: number of byte entries; power of two, 4..256.
- `AF_THRESH`, 12: `almost_full` asserts when level ≥ this value; range 1..DEPTH.
- `clk` input 1: system clock; single clock domain.
- `rst_n` input 1: reset, asynchronous and active-low.
- `rx_data` input 8: byte from the UART receiver; valid only when `rx_done`=1.
- `rx_done` input 1: one-cycle write strobe from the receiver.
- `rd_ready` input 1: consumer accepts `rd_data` this cycle.
- `ovr_clr` input 1: clears `overrun` and `ovr_count`.
- `rd_data` output 8: head byte.
- `rd_valid` output 1: head byte present (buffer not empty).
- `level` output $clog2(DEPTH)+1: current number of stored bytes, 0..DEPTH.
- `full` output 1: level == DEPTH.
- `almost_full` output 1: level ≥ AF_THRESH.
- `overrun` output 1: sticky; a byte was dropped.
- `ovr_count` output 8: dropped-byte count; saturates at 255.

## Operation
- Storage: DEPTH×8 register array. `wr_ptr` and `rd_ptr` are each $clog2(DEPTH)+1 bits wide, and the extra MSB distinguishes full from empty.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - The pointers wrap naturally modulo 2·DEPTH.
- Write accept: `wr_en = rx_done && (!full || rd_fire)`, where `rd_fire = rd_valid && rd_ready`.
  - On accept: mem[wr_ptr low bits] ← rx_data, and wr_ptr increments.
- Read: on `rd_fire`, rd_ptr increments.
  - `rd_ready` while empty is ignored; pointers are unchanged.
- Simultaneous read and write:
  - Both happen, and level is unchanged.
  - When full, the read frees a slot and the write is accepted (no overrun).
  - When empty, only the write happens, because rd_valid=0.
- Overrun: `rx_done && full && !rd_fire` drops the byte.
  - Sets `overrun` and increments `ovr_count` (saturating at 255).
  - Pointers and memory are unchanged.
- `ovr_clr` clears `overrun` and zeroes `ovr_count`. If `ovr_clr` and a new drop occur in the same cycle, the drop wins: overrun=1 and ovr_count=1.
- `level` is kept as a registered counter and must always equal wr_ptr−rd_ptr (modulo 2·DEPTH).
  - Update rule: +1 on write only, −1 on read only, unchanged on both or neither.
- No FSM. Sequential elements: pointers, level counter, array, overrun flag, overrun counter.

## Timing
- Reset (rst_n=0, asynchronous):
  - Pointers and level go to 0.
  - Outputs: rd_valid=0, full=0, almost_full=0, overrun=0, ovr_count=0, rd_data=0.
  - Array contents are don't-care.
- Reset asserted mid-operation discards all buffered bytes immediately.
- Deassertion is synchronous to `clk` and takes effect at the first rising edge after release.
- Write-to-read latency:
  - A byte accepted at edge N appears on `rd_data` with `rd_valid`=1 after edge N (visible in cycle N+1).
  - `level`, `full` and `almost_full` update after the same edge.
- `rd_data` is combinational from mem[rd_ptr] (first-word-fall-through). It is held stable while rd_valid=1 and rd_ready=0.
- `rd_data` is forced to 0 when empty.
- Flags are derived from registered state only, so there is no combinational path from `rd_ready` to the flags.
- Throughput: one write and one read per cycle, sustained.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_BITS`=8.
  - Default FIFO depth and AF threshold constants.
  - The same data-width constant used by the receiver and transmitter.
- One natural sub-module, `uart_fifo_mem`: a DEPTH×8 array with a synchronous write port and an asynchronous read port. It keeps storage separable for later RAM inference.
- Pointer, flag and overrun logic stay in `uart_rx_fifo`.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 via rx_done pulses with rd_ready=0.
  - Required: level=3 and rd_data=0x41.
  - Then rd_ready=1 for 3 cycles, required to read 0x41, 0x42, 0x43 in order, ending with rd_valid=0 and level=0.
- Fill 16 bytes (0x00..0x0F).
  - Required: almost_full rises on the 12th write and full rises on the 16th.
  - Then write 0xAA with rd_ready=0, required: overrun=1, ovr_count=1, level=16, and the head is still 0x00.
- Full buffer, then rx_done=1 (0x55) with rd_ready=1 in the same cycle.
  - Required: level stays 16, overrun stays 0, and 0x55 is read last after 15 more reads.
- 300 drops while full.
  - Required: ovr_count saturates at 255.
  - Then ovr_clr together with another drop, required: overrun=1 and ovr_count=1.
- Pointer wrap: 40 write/read pairs with random spacing.
  - Required: data order preserved throughout, and level always equals outstanding writes.
- Assert rst_n=0 mid-stream with 5 bytes buffered.
  - Required: rd_valid, level and full drop to 0 immediately, before the next clock edge, and no stale byte appears after release.
